// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) multiply-by-constant functions built from
// xtime chains, the column-serial stage FSM encoding and state geometry.
// The SubBytes and key-expansion stages import the same package.
package aes_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;
   localparam int NCOL    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_e;

   // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // 9 = 8 + 1
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   // 0B = 8 + 2 + 1
   function automatic logic [7:0] gf_mulb(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   // 0D = 8 + 4 + 1
   function automatic logic [7:0] gf_muld(input logic [7:0] b);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   // 0E = 8 + 4 + 2
   function automatic logic [7:0] gf_mule(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/mix_columns_serial_if.sv
// Handshake bundle between ShiftRows, the column-serial mixer and
// AddRoundKey. The master side is the upstream/downstream environment,
// the slave side is the mixer stage itself.
interface mix_columns_serial_if;
   import aes_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [0:STATE_W-1]   in_state;
   logic                 in_inv;
   logic                 in_bypass;
   logic                 out_valid;
   logic                 out_ready;
   logic [0:STATE_W-1]   out_state;

   modport master (
      output in_valid,
      output in_state,
      output in_inv,
      output in_bypass,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state
   );

   modport slave (
      input  in_valid,
      input  in_state,
      input  in_inv,
      input  in_bypass,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state
   );

endinterface

// File: rtl/mix_column_word.sv
// Single 32-bit column mixer, purely combinational. Row 0 sits in the
// most significant byte of the word. Forward and inverse use the same
// rotating coefficient pattern with {02,03,01,01} or {0E,0B,0D,09}.
module mix_column_word
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col,
   input  logic             inv,
   output logic [COL_W-1:0] mixed
);

   logic [7:0] a0;
   logic [7:0] a1;
   logic [7:0] a2;
   logic [7:0] a3;

   assign a0 = col[31:24];
   assign a1 = col[23:16];
   assign a2 = col[15:8];
   assign a3 = col[7:0];

   // Select forward or inverse matrix product for this column
   always_comb begin
      mixed = '0;
      if (inv) begin
         mixed[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
         mixed[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
         mixed[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
         mixed[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
      end else begin
         mixed[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
         mixed[23:16] = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
         mixed[15:8]  = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
         mixed[7:0]   = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
      end
   end

endmodule

// File: rtl/mix_columns_serial.sv
// Column-serial MixColumns / InvMixColumns stage. A block is captured
// into the work register, then one column per cycle is passed through
// the shared mixer and written back in place. Bypass blocks skip the
// column passes and are presented on the very next cycle, which is what
// the final AES round needs.
module mix_columns_serial
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   mix_columns_serial_if.slave   bus
);

   mc_state_e            state;
   mc_state_e            state_next;
   logic [1:0]           col;
   logic [0:STATE_W-1]   work;
   logic                 inv;
   logic                 bypass;
   logic                 ready_en;
   logic                 accept;
   logic                 in_ready_int;
   logic [COL_W-1:0]     col_word;
   logic [COL_W-1:0]     col_mixed;

   // in_ready must stay low while reset is held and only rise on the
   // first clock after release, so it is gated by this flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Pick the column currently being transformed out of the work register
   always_comb begin
      col_word = work[COL_W*int'(col) +: COL_W];
   end

   mix_column_word u_mix (
      .col   (col_word),
      .inv   (inv),
      .mixed (col_mixed)
   );

   // FSM state register; reset discards any block in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode; DONE can hand off and accept in
   // the same cycle so blocks stream back-to-back
   always_comb begin
      state_next    = state;
      in_ready_int  = 1'b0;
      accept        = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready_int = ready_en;
            if (ready_en && bus.in_valid) begin
               accept     = 1'b1;
               state_next = bus.in_bypass ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (col == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               in_ready_int = ready_en;
               if (ready_en && bus.in_valid) begin
                  accept     = 1'b1;
                  state_next = bus.in_bypass ? DONE : BUSY;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_state = work;

   // Work register, mode flags and column counter; a new block overwrites
   // everything, otherwise BUSY writes back one mixed column per cycle and
   // the 2-bit counter wraps to 0 as the last column is written. The
   // bypass flag also blocks write-back as a guard against a stray BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         inv    <= 1'b0;
         bypass <= 1'b0;
         col    <= 2'd0;
      end else if (accept) begin
         work   <= bus.in_state;
         inv    <= bus.in_inv;
         bypass <= bus.in_bypass;
         col    <= 2'd0;
      end else if (state == BUSY && !bypass) begin
         work[COL_W*int'(col) +: COL_W] <= col_mixed;
         col                            <= col + 2'd1;
      end
   end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Self-checking bench for mix_columns_serial. Expected blocks are queued
// when a block is accepted and compared when the stage hands a result
// downstream, together with the cycle on which it was expected.
module tb_mix_columns_serial;
   import aes_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mix_columns_serial_if bif();

   mix_columns_serial dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   typedef struct {
      logic [0:127] data;
      int           due;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [0:127] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [0:127] SC_IN    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [0:127] SC_OUT   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

   // Count active edges so latencies can be checked in cycles
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Generic shift-and-add GF(2^8) multiply
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // Whole-state reference using the circulant coefficient matrix
   function automatic logic [0:127] mixModel(input logic [0:127] st, input bit inv);
      logic [7:0]   coef [4];
      logic [7:0]   b;
      logic [0:127] r;
      if (inv) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) begin
               b ^= gmul(coef[(j - row + 4) % 4], st[32*c + 8*j +: 8]);
            end
            r[32*c + 8*row +: 8] = b;
         end
      end
      return r;
   endfunction

   // Drive one block until accepted; called at posedge+1, returns at
   // posedge+1 after the acceptance edge so calls can chain without gaps
   task automatic applyStimulus(input logic [0:127] st, input bit inv, input bit byp,
                                input logic [0:127] exp, input bit timed, output int acc);
      exp_t e;
      int   n;
      n             = 0;
      acc           = -1;
      bif.in_valid  = 1'b1;
      bif.in_state  = st;
      bif.in_inv    = inv;
      bif.in_bypass = byp;
      while (acc < 0 && n < 200) begin
         @(negedge clk);
         if (bif.in_ready) acc = cyc + 1;
         n++;
      end
      if (acc < 0) begin
         checkOutput("accept_timeout", 0, 1);
         bif.in_valid = 1'b0;
         return;
      end
      e.data = exp;
      e.due  = timed ? acc + (byp ? 0 : 4) : -1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      bif.in_valid  = 1'b0;
      bif.in_inv    = 1'b0;
      bif.in_bypass = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (sbq.size() != 0) checkOutput("drain_timeout", sbq.size(), 0);
   endtask

   // Scoreboard side: every downstream transfer pops one expected block
   always @(negedge clk) begin
      if (rst_n && bif.out_valid && bif.out_ready) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_out", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            checkOutput("out_state", bif.out_state, mon_e.data);
            if (mon_e.due >= 0) checkOutput("out_cycle", cyc, mon_e.due);
         end
      end
   end

   initial begin
      int           acc;
      int           prev_acc;
      int           prev_gap;
      int           call_cyc;
      int           n;
      logic [0:127] held;
      logic [0:127] st;
      bit           ri;
      bit           rb;

      bif.in_valid  = 1'b0;
      bif.in_state  = '0;
      bif.in_inv    = 1'b0;
      bif.in_bypass = 1'b0;
      bif.out_ready = 1'b1;

      // Reset values and in_ready release timing
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", bif.out_valid, 0);
      checkOutput("rst_out_state", bif.out_state, 0);
      checkOutput("rst_in_ready", bif.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready_low", bif.in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("rel_in_ready_high", bif.in_ready, 1);

      // Known vectors, forward then inverse
      applyStimulus(FIPS_IN,  1'b0, 1'b0, FIPS_OUT, 1'b1, acc);
      applyStimulus(FIPS_OUT, 1'b1, 1'b0, FIPS_IN,  1'b1, acc);
      applyStimulus(SC_IN,    1'b0, 1'b0, SC_OUT,   1'b1, acc);
      applyStimulus(SC_OUT,   1'b1, 1'b0, SC_IN,    1'b1, acc);
      waitDrain();

      // Bypass alone, then bypass and mix alternating with no bubbles
      applyStimulus(FIPS_IN, 1'b1, 1'b1, FIPS_IN, 1'b1, acc);
      waitDrain();
      prev_acc = 0;
      prev_gap = 0;
      for (int i = 0; i < 8; i++) begin
         st = {$urandom, $urandom, $urandom, $urandom};
         ri = 1'($urandom_range(0, 1));
         rb = (i % 2 == 0);
         applyStimulus(st, ri, rb, rb ? st : mixModel(st, ri), 1'b1, acc);
         if (i > 0) checkOutput("b2b_accept_cycle", acc, prev_acc + prev_gap);
         prev_acc = acc;
         prev_gap = rb ? 1 : 5;
      end
      waitDrain();

      // Backpressure: result must hold, in_ready low, junk input ignored
      bif.out_ready = 1'b0;
      applyStimulus(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 1'b0, acc);
      n = 0;
      while (!bif.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bp_out_valid", bif.out_valid, 1);
      held = bif.out_state;
      checkOutput("bp_held_value", held, FIPS_OUT);
      bif.in_valid = 1'b1;
      bif.in_state = ~FIPS_IN;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_valid_stable", bif.out_valid, 1);
         checkOutput("bp_state_stable", bif.out_state, held);
         checkOutput("bp_in_ready_low", bif.in_ready, 0);
      end
      @(posedge clk);
      #1;
      bif.out_ready = 1'b1;
      call_cyc = cyc;
      applyStimulus(SC_IN, 1'b0, 1'b0, SC_OUT, 1'b1, acc);
      checkOutput("bp_same_cycle_accept", acc, call_cyc + 1);
      waitDrain();

      // Reset after two column edges discards the block
      applyStimulus(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 1'b1, acc);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sbq.delete();
      #1;
      checkOutput("midrst_out_valid", bif.out_valid, 0);
      checkOutput("midrst_out_state", bif.out_state, 0);
      checkOutput("midrst_in_ready", bif.in_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_rel_ready", bif.in_ready, 1);
      applyStimulus(FIPS_IN,  1'b0, 1'b0, FIPS_OUT, 1'b1, acc);
      applyStimulus(FIPS_OUT, 1'b1, 1'b0, FIPS_IN,  1'b1, acc);
      waitDrain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
